// File: rtl/riscv_trap_ctrl_pkg.sv
// riscv_trap_ctrl_pkg: CSR addresses, cause codes, request types and trap FSM states
package riscv_trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE = 12'h304;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [30:0] CAUSE_ECALL = 31'd11;
  localparam logic [30:0] CAUSE_EBREAK = 31'd3;
  localparam logic [30:0] CAUSE_ILLEGAL = 31'd2;
  localparam logic [30:0] CAUSE_MTI = 31'd7;
  typedef enum logic [1:0] {T_ECALL, T_EBREAK, T_MRET, T_ILLEGAL} trap_type_e;
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, VEC, R_EPC, MRET_STATUS, REDIRECT} state_e;
  function automatic logic [30:0] exc_code(trap_type_e t);
    return t == T_ECALL ? CAUSE_ECALL : t == T_EBREAK ? CAUSE_EBREAK : CAUSE_ILLEGAL;
  endfunction
endpackage

// File: rtl/riscv_trap_ctrl_if.sv
// riscv_trap_ctrl_if: single-write / single-combinational-read CSR port
interface riscv_trap_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic csr_wr_valid_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr_o;
  logic [DATA_WIDTH-1:0] csr_wr_data_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_rd_addr_o;
  logic [DATA_WIDTH-1:0] csr_rd_data_i;
  modport master (output csr_wr_valid_o, csr_wr_addr_o, csr_wr_data_o, csr_rd_addr_o, input csr_rd_data_i);
  modport slave (input csr_wr_valid_o, csr_wr_addr_o, csr_wr_data_o, csr_rd_addr_o, output csr_rd_data_i);
endinterface

// File: rtl/riscv_trap_ctrl_mstatus_upd.sv
// riscv_mstatus_upd: mstatus MIE/MPIE/MPP update on trap entry or mret
module riscv_mstatus_upd #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic                  mret_i,
  output logic [DATA_WIDTH-1:0] new_o
);
  always_comb begin
    new_o = old_i;
    new_o[3] = mret_i ? old_i[7] : 1'b0;
    new_o[7] = mret_i ? 1'b1 : old_i[3];
    new_o[12:11] = mret_i ? 2'b00 : 2'b11;
  end
endmodule

// File: rtl/riscv_trap_ctrl.sv
// riscv_trap_ctrl: arbitrates traps/mret/timer irq and sequences CSR save/restore plus PC redirect
module riscv_trap_ctrl
  import riscv_trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_req_i,
  input  logic [1:0]            trap_type_i,
  input  logic [DATA_WIDTH-1:0] trap_pc_i,
  input  logic [DATA_WIDTH-1:0] irq_pc_i,
  input  logic                  timer_irq_i,
  input  logic                  mie_mtie_i,
  output logic                  trap_ack_o,
  output logic                  irq_ack_o,
  output logic                  busy_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  riscv_trap_ctrl_if.master     csr
);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS = CSR_ADDR_WIDTH'(CSR_MSTATUS);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC = CSR_ADDR_WIDTH'(CSR_MTVEC);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC = CSR_ADDR_WIDTH'(CSR_MEPC);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE = CSR_ADDR_WIDTH'(CSR_MCAUSE);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d, epc_q, epc_d, target_q, target_d, status_new, base;
  logic idle, irq_pend, st_wr;
  assign idle = state_q == IDLE;
  assign st_wr = state_q == W_STATUS || state_q == MRET_STATUS;
  assign irq_pend = idle & timer_irq_i & mie_mtie_i & csr.csr_rd_data_i[3];
  assign irq_ack_o = irq_pend & ~rst;
  assign trap_ack_o = idle & ~irq_pend & trap_req_i & ~rst;
  assign busy_o = ~idle;
  assign base = {csr.csr_rd_data_i[DATA_WIDTH-1:2], 2'b00};
  assign redirect_valid_o = state_q == REDIRECT;
  assign redirect_pc_o = redirect_valid_o ? target_q : '0;
  assign csr.csr_rd_addr_o = state_q == VEC ? A_MTVEC : state_q == R_EPC ? A_MEPC : (idle || st_wr) ? A_MSTATUS : '0;
  assign csr.csr_wr_valid_o = state_q == W_EPC || state_q == W_CAUSE || st_wr;
  assign csr.csr_wr_addr_o = state_q == W_EPC ? A_MEPC : state_q == W_CAUSE ? A_MCAUSE : st_wr ? A_MSTATUS : '0;
  assign csr.csr_wr_data_o = state_q == W_EPC ? {epc_q[DATA_WIDTH-1:2], 2'b00} : state_q == W_CAUSE ? cause_q : st_wr ? status_new : '0;
  riscv_mstatus_upd #(.DATA_WIDTH(DATA_WIDTH)) u_upd (
    .old_i (csr.csr_rd_data_i),
    .mret_i(state_q == MRET_STATUS),
    .new_o (status_new)
  );
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d = epc_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (irq_pend) begin
          state_d = W_EPC;
          cause_d = {1'b1, (DATA_WIDTH-1)'(CAUSE_MTI)};
          epc_d = irq_pc_i;
        end else if (trap_req_i) begin
          state_d = trap_type_i == T_MRET ? R_EPC : W_EPC;
          if (trap_type_i != T_MRET) begin
            cause_d = {1'b0, (DATA_WIDTH-1)'(exc_code(trap_type_e'(trap_type_i)))};
            epc_d = trap_pc_i;
          end
        end
      end
      W_EPC: state_d = W_CAUSE;
      W_CAUSE: state_d = W_STATUS;
      W_STATUS: state_d = VEC;
      VEC: begin
        state_d = REDIRECT;
        target_d = (csr.csr_rd_data_i[1:0] == 2'b01 && cause_q[DATA_WIDTH-1]) ? base + {cause_q[DATA_WIDTH-3:0], 2'b00} : base;
      end
      R_EPC: begin
        state_d = MRET_STATUS;
        target_d = csr.csr_rd_data_i;
      end
      MRET_STATUS: state_d = REDIRECT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q <= epc_d;
      target_q <= target_d;
    end
  end
endmodule
